// File: rtl/audiodac_dsmod_mc_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma modulator.
// Holds OSR codes, loop-order encoding, the mute scale code and the dither LFSR taps.
package audiodac_dsmod_mc_pkg;

    localparam logic [2:0] OSR_32  = 3'd0;
    localparam logic [2:0] OSR_64  = 3'd1;
    localparam logic [2:0] OSR_128 = 3'd2;
    localparam logic [2:0] OSR_256 = 3'd3;
    localparam logic [2:0] OSR_512 = 3'd4;

    typedef enum logic {
        MODE_ORD1 = 1'b0,
        MODE_ORD2 = 1'b1
    } mode_e;

    localparam logic [3:0] SCALE_OFF = 4'd15;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [8:0] osr_reload(input logic [2:0] osr);
        case (osr)
            OSR_32:  return 9'd31;
            OSR_64:  return 9'd63;
            OSR_128: return 9'd127;
            OSR_256: return 9'd255;
            default: return 9'd511;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/audiodac_dsmod_mc_core.sv
// One modulator channel: offset removal, 6 dB-step scaling, dither, and
// a 1st-order carry loop plus a 2nd-order error-feedback loop with saturating integrators.
module audiodac_dsmod_mc_core
    import audiodac_dsmod_mc_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [BW-1:0] hold_i,
    input  logic [3:0]    scale_i,
    input  mode_e         mode_i,
    input  logic          dither_en_i,
    input  logic          dither_bit_i,
    input  logic          int_clr_i,
    output logic          ds_o
);

    localparam int IW = BW + 3;
    localparam int EW = BW + 5;

    localparam logic [BW:0]          MID_X  = {2'b01, {(BW-1){1'b0}}};
    localparam logic signed [BW+1:0] X_MAX  = {3'b000, {(BW-1){1'b1}}};
    localparam logic signed [BW+1:0] X_MIN  = {3'b111, {(BW-1){1'b0}}};
    localparam logic signed [BW+1:0] DITH_P = {{(BW+1){1'b0}}, 1'b1};
    localparam logic signed [BW+1:0] DITH_N = {(BW+2){1'b1}};
    localparam logic signed [EW-1:0] FB_P   = {5'b00000, 1'b1, {(BW-1){1'b0}}};
    localparam logic signed [EW-1:0] FB_N   = {6'b111111, {(BW-1){1'b0}}};
    localparam logic signed [EW-1:0] I_MAX  = {4'b0000, {(BW+1){1'b1}}};
    localparam logic signed [EW-1:0] I_MIN  = {4'b1111, {BW{1'b0}}, 1'b1};

    logic [BW-1:0]        a1_q, a1_d;
    logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
    logic                 ds_q, ds_d;

    logic signed [BW:0]   diff, shifted, x_scl, x;
    logic signed [BW+1:0] x_dit;
    logic [BW-1:0]        xu;
    logic [BW:0]          sum1;
    logic signed [EW-1:0] x_e, i1_e, i2_e, fb, s1, s2;
    logic signed [IW-1:0] i1_n, i2_n;

    function automatic logic signed [IW-1:0] sat_i(input logic signed [EW-1:0] v);
        if (v > I_MAX)      return I_MAX[IW-1:0];
        else if (v < I_MIN) return I_MIN[IW-1:0];
        else                return v[IW-1:0];
    endfunction

    always_comb begin
        diff    = $signed({1'b0, hold_i}) - $signed(MID_X);
        shifted = diff >>> scale_i;
        x_scl   = (scale_i == SCALE_OFF) ? '0 : shifted;
        x_dit   = {x_scl[BW], x_scl};
        if (dither_en_i) begin
            x_dit = x_dit + (dither_bit_i ? DITH_P : DITH_N);
        end
        if (x_dit > X_MAX)      x = X_MAX[BW:0];
        else if (x_dit < X_MIN) x = X_MIN[BW:0];
        else                    x = x_dit[BW:0];

        // x + MID over BW bits is just the sign bit flipped.
        xu   = {~x[BW-1], x[BW-2:0]};
        sum1 = {1'b0, xu} + {1'b0, a1_q};

        x_e  = {{4{x[BW]}}, x};
        i1_e = {{2{i1_q[IW-1]}}, i1_q};
        i2_e = {{2{i2_q[IW-1]}}, i2_q};
        fb   = ds_q ? FB_P : FB_N;
        s1   = i1_e + x_e - fb;
        s2   = i2_e + i1_e - fb;
        i1_n = sat_i(s1);
        i2_n = sat_i(s2);

        a1_d = a1_q;
        i1_d = i1_q;
        i2_d = i2_q;
        if (int_clr_i) begin
            a1_d = '0;
            i1_d = '0;
            i2_d = '0;
        end else if (mode_i == MODE_ORD2) begin
            a1_d = '0;
            i1_d = i1_n;
            i2_d = i2_n;
        end else begin
            a1_d = sum1[BW-1:0];
            i1_d = '0;
            i2_d = '0;
        end
        ds_d = (mode_i == MODE_ORD2) ? ~i2_n[IW-1] : sum1[BW];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a1_q <= '0;
            i1_q <= '0;
            i2_q <= '0;
            ds_q <= 1'b0;
        end else begin
            a1_q <= a1_d;
            i1_q <= i1_d;
            i2_q <= i2_d;
            ds_q <= ds_d;
        end
    end

    assign ds_o = ds_q;

endmodule

// File: rtl/audiodac_dsmod_mc.sv
// Multi-channel delta-sigma modulator top: sample fetch counter, scale ramp,
// mode tracking, shared dither LFSR and sticky underrun flag around NCH channel cores.
module audiodac_dsmod_mc
    import audiodac_dsmod_mc_pkg::*;
#(
    parameter int          BW        = 16,
    parameter int          NCH       = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NCH*BW-1:0] data_i,
    input  logic              data_vld_i,
    output logic              data_rd_o,
    output logic [NCH-1:0]    ds_o,
    output logic [NCH-1:0]    ds_n_o,
    input  logic              mode_i,
    input  logic [3:0]        scale_i,
    input  logic [2:0]        osr_i,
    input  logic              dither_en_i,
    output logic              underrun_o,
    input  logic              underrun_clr_i
);

    localparam logic [BW-1:0] MID = {1'b1, {(BW-1){1'b0}}};

    logic [8:0]        fetch_ctr_q, fetch_ctr_d;
    logic [NCH*BW-1:0] hold_q, hold_d;
    logic [3:0]        eff_scale_q, eff_scale_d;
    mode_e             mode_q, mode_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              underrun_q, underrun_d;
    logic              boundary, int_clr;
    logic [NCH-1:0]    ds_bits;

    // Fetch handshake: data_rd_o is a combinational strobe at every sample boundary;
    // a frame is consumed iff data_rd_o && data_vld_i in the same cycle, otherwise
    // the held frame repeats and the underrun flag is set.
    assign boundary  = (fetch_ctr_q == 9'd0);
    assign data_rd_o = boundary;

    always_comb begin
        fetch_ctr_d = boundary ? osr_reload(osr_i) : fetch_ctr_q - 9'd1;
        hold_d      = (boundary && data_vld_i) ? data_i : hold_q;

        eff_scale_d = eff_scale_q;
        if (boundary) begin
            if (eff_scale_q < scale_i)      eff_scale_d = eff_scale_q + 4'd1;
            else if (eff_scale_q > scale_i) eff_scale_d = eff_scale_q - 4'd1;
        end

        mode_d  = boundary ? mode_e'(mode_i) : mode_q;
        int_clr = boundary && (mode_e'(mode_i) != mode_q);
        lfsr_d  = lfsr_next(lfsr_q);

        if (boundary && !data_vld_i) underrun_d = 1'b1;
        else if (underrun_clr_i)     underrun_d = 1'b0;
        else                         underrun_d = underrun_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_ctr_q <= '0;
            hold_q      <= {NCH{MID}};
            eff_scale_q <= SCALE_OFF;
            mode_q      <= MODE_ORD1;
            lfsr_q      <= LFSR_SEED;
            underrun_q  <= 1'b0;
        end else begin
            fetch_ctr_q <= fetch_ctr_d;
            hold_q      <= hold_d;
            eff_scale_q <= eff_scale_d;
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
            underrun_q  <= underrun_d;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        audiodac_dsmod_mc_core #(.BW(BW)) u_core (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .hold_i      (hold_q[ch*BW +: BW]),
            .scale_i     (eff_scale_q),
            .mode_i      (mode_q),
            .dither_en_i (dither_en_i),
            .dither_bit_i(lfsr_q[0]),
            .int_clr_i   (int_clr),
            .ds_o        (ds_bits[ch])
        );
    end

    assign ds_o       = ds_bits;
    assign ds_n_o     = ~ds_bits;
    assign underrun_o = underrun_q;

endmodule
